// File: rtl/radix4_pkg.sv
// Shared definitions for the radix-4 Booth multiplier control slice.
//   state_t     : sequencer state encoding (3-bit)
//   booth_ctl_t : decoded Booth digit controls {add_en, sub, dbl}
//   CNT_W       : width of the iteration down-counter
package radix4_pkg;

  localparam int CNT_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_EVAL  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  typedef struct packed {
    logic add_en;  // digit is nonzero
    logic sub;     // digit is negative
    logic dbl;     // |digit| == 2, select 2M
  } booth_ctl_t;

endpackage

// File: rtl/radix4_booth_ctrl_booth_recode.sv
// Radix-4 Booth recoder, purely combinational.
//   q_bits : Booth window {Q[1], Q[0], Q[-1]}
//   ctl    : {add_en, sub, dbl} for the selected digit
module booth_recode
  import radix4_pkg::*;
(
  input  logic [2:0] q_bits,
  output booth_ctl_t ctl
);

  // Map the 3-bit window onto digit in {-2,-1,0,+1,+2}.
  always_comb begin
    ctl = '{add_en: 1'b0, sub: 1'b0, dbl: 1'b0};
    case (q_bits)
      3'b000:  ctl = '{add_en: 1'b0, sub: 1'b0, dbl: 1'b0};  //  0
      3'b001:  ctl = '{add_en: 1'b1, sub: 1'b0, dbl: 1'b0};  // +1
      3'b010:  ctl = '{add_en: 1'b1, sub: 1'b0, dbl: 1'b0};  // +1
      3'b011:  ctl = '{add_en: 1'b1, sub: 1'b0, dbl: 1'b1};  // +2
      3'b100:  ctl = '{add_en: 1'b1, sub: 1'b1, dbl: 1'b1};  // -2
      3'b101:  ctl = '{add_en: 1'b1, sub: 1'b1, dbl: 1'b0};  // -1
      3'b110:  ctl = '{add_en: 1'b1, sub: 1'b1, dbl: 1'b0};  // -1
      3'b111:  ctl = '{add_en: 1'b0, sub: 1'b0, dbl: 1'b0};  //  0
      default: ctl = '{add_en: 1'b0, sub: 1'b0, dbl: 1'b0};
    endcase
  end

endmodule

// File: rtl/radix4_booth_ctrl.sv
// Sequencer for the radix-4 Booth multiplier datapath.
// Issues a load pulse, then WIDTH/2 evaluate/shift pairs, then a done pulse.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : operation request, only honoured in IDLE
//   abort      : synchronous cancel back to IDLE (no done)
//   q_bits     : Booth window from the datapath multiplier register
//   busy/load/eval/shift/done : state-decoded strobes (flop outputs)
//   add_en/sub/dbl : Booth controls, valid only while eval is high
//   cnt        : remaining iterations
module radix4_booth_ctrl
  import radix4_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [2:0]       q_bits,
  output logic             busy,
  output logic             load,
  output logic             eval,
  output logic             add_en,
  output logic             sub,
  output logic             dbl,
  output logic             shift,
  output logic             done,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] ITER    = CNT_W'(WIDTH / 2);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic             busy_r, load_r, eval_r, shift_r, done_r;
  logic             cnt_zero_s, cnt_last_s;
  booth_ctl_t       ctl_s;

  assign cnt_zero_s = ~|cnt_r;
  assign cnt_last_s = (cnt_r == CNT_ONE);

  booth_recode u_recode (
    .q_bits (q_bits),
    .ctl    (ctl_s)
  );

  // Next-state and next-count logic; abort overrides everything.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    if (abort) begin
      state_nxt_s = ST_IDLE;
      cnt_nxt_s   = {CNT_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) state_nxt_s = ST_LOAD;
          else       state_nxt_s = ST_IDLE;
        end
        ST_LOAD: begin
          cnt_nxt_s   = ITER;
          state_nxt_s = ST_EVAL;
        end
        ST_EVAL: begin
          state_nxt_s = ST_SHIFT;
        end
        ST_SHIFT: begin
          // Saturate at zero so a corrupted count can never wrap.
          if (!cnt_zero_s) cnt_nxt_s = cnt_r - CNT_ONE;
          else             cnt_nxt_s = {CNT_W{1'b0}};
          if (cnt_last_s || cnt_zero_s) state_nxt_s = ST_DONE;
          else                          state_nxt_s = ST_EVAL;
        end
        ST_DONE: begin
          state_nxt_s = ST_IDLE;
        end
        default: begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // State, counter and state-decoded strobes; strobes are decoded from the
  // next state so they leave the block straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      busy_r  <= 1'b0;
      load_r  <= 1'b0;
      eval_r  <= 1'b0;
      shift_r <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      busy_r  <= (state_nxt_s != ST_IDLE);
      load_r  <= (state_nxt_s == ST_LOAD);
      eval_r  <= (state_nxt_s == ST_EVAL);
      shift_r <= (state_nxt_s == ST_SHIFT);
      done_r  <= (state_nxt_s == ST_DONE);
    end
  end

  assign busy  = busy_r;
  assign load  = load_r;
  assign eval  = eval_r;
  assign shift = shift_r;
  assign done  = done_r;
  assign cnt   = cnt_r;

  // Gating with eval_r keeps an unknown q_bits outside EVAL off the outputs.
  assign add_en = eval_r & ctl_s.add_en;
  assign sub    = eval_r & ctl_s.sub;
  assign dbl    = eval_r & ctl_s.dbl;

endmodule

// File: tb/tb_radix4_booth_ctrl.sv
// Directed bench for radix4_booth_ctrl (WIDTH=8, ITER=4).
// Cycle r=1 is the LOAD cycle of an operation; outputs are sampled on the
// falling clock edge.
module tb_radix4_booth_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, start, abort;
  logic [2:0] q_bits;
  logic       busy, load, eval, add_en, sub, dbl, shift, done;
  logic [2:0] cnt;

  int total = 0;
  int bad   = 0;

  // Expected {add_en,sub,dbl} for q_bits 000..111.
  logic [2:0] dec_tab [8] = '{3'b000, 3'b100, 3'b100, 3'b101,
                              3'b111, 3'b110, 3'b110, 3'b000};

  logic [4:0] flags;
  logic [2:0] ctl;
  assign flags = {busy, load, eval, shift, done};
  assign ctl   = {add_en, sub, dbl};

  always #5 clk = ~clk;

  radix4_booth_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .q_bits(q_bits),
    .busy(busy), .load(load), .eval(eval), .add_en(add_en), .sub(sub),
    .dbl(dbl), .shift(shift), .done(done), .cnt(cnt)
  );

  // Expected {busy,load,eval,shift,done} in operation cycle r.
  function automatic logic [4:0] m_flags(input int r);
    if (r == 1)                       return 5'b11000;
    else if (r >= 2 && r <= 9)        return (r % 2 == 0) ? 5'b10100 : 5'b10010;
    else if (r == 10)                 return 5'b10001;
    else                              return 5'b00000;
  endfunction

  // Expected cnt in operation cycle r.
  function automatic logic [2:0] m_cnt(input int r);
    if (r >= 2 && r <= 9) return 3'(4 - (r - 2) / 2);
    else                  return 3'd0;
  endfunction

  // Pulse start for edge 0; returns in cycle 1 (LOAD).
  task automatic launch();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; q_bits = 3'b000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total++;
      if ({flags, cnt, ctl} !== 11'b0) begin
        bad++;
        $display("FAIL reset_idle i=%0d got=%b exp=%b", i, {flags, cnt, ctl}, 11'b0);
      end
    end
  endtask

  task automatic test_basic();
    q_bits = 3'b000;
    launch();
    for (int r = 1; r <= 11; r++) begin
      total++;
      if ({flags, cnt} !== {m_flags(r), m_cnt(r)}) begin
        bad++;
        $display("FAIL basic r=%0d got=%b/%0d exp=%b/%0d", r, flags, cnt, m_flags(r), m_cnt(r));
      end
      total++;
      if (ctl !== 3'b000) begin
        bad++;
        $display("FAIL basic_ctl r=%0d got=%b exp=000", r, ctl);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_recode();
    for (int op = 0; op < 2; op++) begin
      launch();
      for (int r = 1; r <= 10; r++) begin
        logic [2:0] exp;
        int idx;
        idx = op * 4 + (r - 2) / 2;
        if (r == 1 || r == 10) q_bits = 3'bxxx;
        else if (r % 2 == 0)   q_bits = 3'(idx);
        else                   q_bits = q_bits;
        #1;
        exp = (r >= 2 && r <= 9 && r % 2 == 0) ? dec_tab[idx] : 3'b000;
        total++;
        if (ctl !== exp) begin
          bad++;
          $display("FAIL recode op=%0d r=%0d q=%b got=%b exp=%b", op, r, q_bits, ctl, exp);
        end
        @(negedge clk);
      end
      q_bits = 3'bxxx;
      #1;
      total++;
      if (ctl !== 3'b000) begin
        bad++;
        $display("FAIL recode_idle_x got=%b exp=000", ctl);
      end
      @(negedge clk);
      q_bits = 3'b000;
    end
  endtask

  task automatic test_abort();
    launch();
    for (int r = 1; r <= 4; r++) @(negedge clk);
    abort = 1'b1;                     // sampled at the edge ending cycle 5
    @(negedge clk);
    abort = 1'b0;
    total++;
    if ({flags, cnt} !== 8'b0) begin
      bad++;
      $display("FAIL abort_idle got=%b/%0d exp=00000/0", flags, cnt);
    end
    launch();                         // start in cycle 6 -> LOAD in cycle 7
    for (int r = 1; r <= 10; r++) begin
      total++;
      if ({flags, cnt} !== {m_flags(r), m_cnt(r)}) begin
        bad++;
        $display("FAIL abort_restart r=%0d got=%b/%0d exp=%b/%0d", r, flags, cnt, m_flags(r), m_cnt(r));
      end
      @(negedge clk);
    end
    start = 1'b1; abort = 1'b1;       // abort wins over start in IDLE
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    total++;
    if ({busy, load} !== 2'b00) begin
      bad++;
      $display("FAIL abort_vs_start got=%b exp=00", {busy, load});
    end
  endtask

  task automatic test_back_to_back();
    int loads, dones;
    loads = 0; dones = 0;
    start = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= 22; c++) begin
      int r;
      r = (c <= 11) ? c : c - 11;
      total++;
      if ({flags, cnt} !== {m_flags(r), m_cnt(r)}) begin
        bad++;
        $display("FAIL b2b c=%0d got=%b/%0d exp=%b/%0d", c, flags, cnt, m_flags(r), m_cnt(r));
      end
      if (load === 1'b1) loads++;
      if (done === 1'b1) dones++;
      if (c == 22) begin
        start = 1'b0;
        abort = 1'b1;
      end
      @(negedge clk);
    end
    abort = 1'b0;
    total++;
    if (loads != 2 || dones != 2) begin
      bad++;
      $display("FAIL b2b_counts got=%0d/%0d exp=2/2", loads, dones);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL b2b_final_idle got=%b exp=0", busy);
    end
  endtask

  task automatic test_async_reset();
    launch();
    for (int r = 1; r < 7; r++) @(negedge clk);
    total++;
    if ({shift, cnt} !== {1'b1, 3'd2}) begin
      bad++;
      $display("FAIL async_pre got=%b/%0d exp=1/2", shift, cnt);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({busy, shift, cnt} !== 5'b0) begin
      bad++;
      $display("FAIL async_reset got=%b/%b/%0d exp=0/0/0", busy, shift, cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      total++;
      if ({busy, done} !== 2'b00) begin
        bad++;
        $display("FAIL async_after i=%0d got=%b exp=00", i, {busy, done});
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_recode();
    test_abort();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
